// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: a BHT of 2-bit saturating counters and a BTB.
// IF reads a taken/target prediction combinationally. EX trains the tables with
// resolved conditional branches and raises a redirect request on a misprediction.
module branch_predictor #(
    parameter int unsigned INDEX_W = 6
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    // predict port (IF)
    input  logic [31:0] pc_if_i,
    output logic        pred_taken_o,
    output logic [31:0] pred_target_o,
    // update port (EX)
    input  logic        update_en_i,
    input  logic [31:0] pc_ex_i,
    input  logic [31:0] target_ex_i,
    input  logic [2:0]  br_funct3_i,
    input  logic        br_less_i,
    input  logic        br_equal_i,
    input  logic        pred_taken_ex_i,
    input  logic [31:0] pred_target_ex_i,
    output logic        actual_taken_o,
    output logic        mispredict_o
);

    localparam int unsigned TAG_W   = 30 - INDEX_W;
    localparam int unsigned ENTRIES = 1 << INDEX_W;

    // Per-entry direction counter states
    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    logic              valid_q  [ENTRIES];
    logic              valid_d  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [TAG_W-1:0]  tag_d    [ENTRIES];
    logic [31:0]       target_q [ENTRIES];
    logic [31:0]       target_d [ENTRIES];
    ctr_e              ctr_q    [ENTRIES];
    ctr_e              ctr_d    [ENTRIES];

    logic [INDEX_W-1:0] if_idx;
    logic [TAG_W-1:0]   if_tag;
    logic [INDEX_W-1:0] ex_idx;
    logic [TAG_W-1:0]   ex_tag;
    logic               if_hit;
    logic               ex_hit;
    logic               br_legal;
    logic               br_dir;
    logic               upd_fire;
    logic               unused_pc_lsbs;

    assign if_idx = pc_if_i[INDEX_W+1:2];
    assign if_tag = pc_if_i[31:INDEX_W+2];
    assign ex_idx = pc_ex_i[INDEX_W+1:2];
    assign ex_tag = pc_ex_i[31:INDEX_W+2];

    // Instructions are word aligned, so the low PC bits never index the tables
    assign unused_pc_lsbs = ^{pc_if_i[1:0], pc_ex_i[1:0]};

    // Counter step toward strongly taken
    function automatic ctr_e sat_inc(input ctr_e c);
        unique case (c)
            CTR_SNT: sat_inc = CTR_WNT;
            CTR_WNT: sat_inc = CTR_WT;
            CTR_WT:  sat_inc = CTR_ST;
            default: sat_inc = CTR_ST;
        endcase
    endfunction

    // Counter step toward strongly not-taken
    function automatic ctr_e sat_dec(input ctr_e c);
        unique case (c)
            CTR_ST:  sat_dec = CTR_WT;
            CTR_WT:  sat_dec = CTR_WNT;
            CTR_WNT: sat_dec = CTR_SNT;
            default: sat_dec = CTR_SNT;
        endcase
    endfunction

    // Prediction lookup; reads current table state (no bypass of a same-cycle update)
    always_comb begin
        if_hit        = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        pred_taken_o  = if_hit && (ctr_q[if_idx] inside {CTR_WT, CTR_ST});
        pred_target_o = pred_taken_o ? target_q[if_idx] : 32'h0;
    end

    // Resolve branch direction from funct3 and comparator flags
    always_comb begin
        br_legal = 1'b1;
        br_dir   = 1'b0;
        unique case (br_funct3_i)
            3'b000:         br_dir = br_equal_i;
            3'b001:         br_dir = !br_equal_i;
            3'b100, 3'b110: br_dir = br_less_i;
            3'b101, 3'b111: br_dir = !br_less_i;
            default:        br_legal = 1'b0;
        endcase
    end

    // Redirect when direction differs, or when taken toward a different target
    always_comb begin
        upd_fire       = update_en_i && br_legal;
        actual_taken_o = upd_fire && br_dir;
        mispredict_o   = upd_fire &&
                         ((br_dir != pred_taken_ex_i) ||
                          (br_dir && (pred_target_ex_i != target_ex_i)));
    end

    // Next-state for the tables: train on hit, allocate on taken miss
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        ex_hit   = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
        if (upd_fire) begin
            if (ex_hit) begin
                if (br_dir) begin
                    ctr_d[ex_idx]    = sat_inc(ctr_q[ex_idx]);
                    target_d[ex_idx] = target_ex_i;
                end else begin
                    ctr_d[ex_idx]    = sat_dec(ctr_q[ex_idx]);
                end
            end else if (br_dir) begin
                valid_d[ex_idx]  = 1'b1;
                tag_d[ex_idx]    = ex_tag;
                target_d[ex_idx] = target_ex_i;
                ctr_d[ex_idx]    = CTR_WT;
            end
        end
    end

    // Table state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= 32'h0;
                ctr_q[i]    <= CTR_WNT;
            end
        end else begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= valid_d[i];
                tag_q[i]    <= tag_d[i];
                target_q[i] <= target_d[i];
                ctr_q[i]    <= ctr_d[i];
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios plus random traffic against a
// table model written with plain integers and whole-PC ownership.
module tb_branch_predictor;

    logic        clk_i;
    logic        rst_ni;
    logic [31:0] pc_if_i;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    logic        update_en_i;
    logic [31:0] pc_ex_i;
    logic [31:0] target_ex_i;
    logic [2:0]  br_funct3_i;
    logic        br_less_i;
    logic        br_equal_i;
    logic        pred_taken_ex_i;
    logic [31:0] pred_target_ex_i;
    logic        actual_taken_o;
    logic        mispredict_o;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: each entry remembers the whole PC that owns it and a 0..3 counter
    bit          m_valid  [64];
    int unsigned m_ctr    [64];
    bit [31:0]   m_owner  [64];
    bit [31:0]   m_target [64];

    branch_predictor dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .pc_if_i          (pc_if_i),
        .pred_taken_o     (pred_taken_o),
        .pred_target_o    (pred_target_o),
        .update_en_i      (update_en_i),
        .pc_ex_i          (pc_ex_i),
        .target_ex_i      (target_ex_i),
        .br_funct3_i      (br_funct3_i),
        .br_less_i        (br_less_i),
        .br_equal_i       (br_equal_i),
        .pred_taken_ex_i  (pred_taken_ex_i),
        .pred_target_ex_i (pred_target_ex_i),
        .actual_taken_o   (actual_taken_o),
        .mispredict_o     (mispredict_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void m_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i]  = 1'b0;
            m_ctr[i]    = 1;
            m_owner[i]  = 32'h0;
            m_target[i] = 32'h0;
        end
    endfunction

    function automatic int m_index(input bit [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    function automatic bit m_hit(input bit [31:0] pc);
        int i;
        i = m_index(pc);
        return m_valid[i] && ((pc / 256) == (m_owner[i] / 256));
    endfunction

    function automatic void m_predict(input bit [31:0] pc, output bit t, output bit [31:0] tg);
        t  = m_hit(pc) && (m_ctr[m_index(pc)] >= 2);
        tg = t ? m_target[m_index(pc)] : 32'h0;
    endfunction

    // RISC-V conditional branch semantics on already-compared flags
    function automatic bit m_dir(input bit [2:0] f3, input bit lt, input bit eq, output bit legal);
        legal = 1'b1;
        case (f3)
            3'd0:       return eq;
            3'd1:       return !eq;
            3'd4, 3'd6: return lt;
            3'd5, 3'd7: return !lt;
            default: begin
                legal = 1'b0;
                return 1'b0;
            end
        endcase
    endfunction

    function automatic void m_update(input bit [31:0] pc, input bit [31:0] tgt, input bit taken);
        int i;
        i = m_index(pc);
        if (m_hit(pc)) begin
            if (taken) begin
                m_ctr[i]    = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                m_target[i] = tgt;
            end else begin
                m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
            end
        end else if (taken) begin
            m_valid[i]  = 1'b1;
            m_owner[i]  = pc;
            m_target[i] = tgt;
            m_ctr[i]    = 2;
        end
    endfunction

    task automatic drive_idle();
        pc_if_i          = 32'h0;
        update_en_i      = 1'b0;
        pc_ex_i          = 32'h0;
        target_ex_i      = 32'h0;
        br_funct3_i      = 3'b000;
        br_less_i        = 1'b0;
        br_equal_i       = 1'b0;
        pred_taken_ex_i  = 1'b0;
        pred_target_ex_i = 32'h0;
    endtask

    // One clock: drive at negedge, sample before posedge, then advance the model
    task automatic cycle(input bit [31:0] pc_if, input bit upd, input bit [31:0] pc_ex,
                         input bit [31:0] tgt, input bit [2:0] f3, input bit lt, input bit eq,
                         input bit pte, input bit [31:0] ptg,
                         output bit o_pt, output bit [31:0] o_ptg, output bit o_act, output bit o_mis);
        bit legal;
        bit dir;
        pc_if_i          = pc_if;
        update_en_i      = upd;
        pc_ex_i          = pc_ex;
        target_ex_i      = tgt;
        br_funct3_i      = f3;
        br_less_i        = lt;
        br_equal_i       = eq;
        pred_taken_ex_i  = pte;
        pred_target_ex_i = ptg;
        #2;
        o_pt  = pred_taken_o;
        o_ptg = pred_target_o;
        o_act = actual_taken_o;
        o_mis = mispredict_o;
        @(posedge clk_i);
        dir = m_dir(f3, lt, eq, legal);
        if (upd && legal) m_update(pc_ex, tgt, dir);
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        bit [31:0] pcs [4];
        pcs = '{32'h100, 32'h0, 32'hFFFF_FFFC, 32'h1234};
        foreach (pcs[k]) begin
            pc_if_i = pcs[k];
            #1;
            n_cmp++;
            if (pred_taken_o !== 1'b0 || pred_target_o !== 32'h0) begin
                n_bad++;
                $display("FAIL reset_pred pc=%h: taken=%b target=%h, want 0/0", pcs[k], pred_taken_o, pred_target_o);
            end
            n_cmp++;
            if (actual_taken_o !== 1'b0 || mispredict_o !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_resolve: actual=%b mis=%b, want 0/0", actual_taken_o, mispredict_o);
            end
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        pc_if_i = 32'h100;
        #2;
        n_cmp++;
        if (pred_taken_o !== 1'b0 || pred_target_o !== 32'h0) begin
            n_bad++;
            $display("FAIL post_reset_pred: taken=%b target=%h, want 0/0", pred_taken_o, pred_target_o);
        end
        @(negedge clk_i);
    endtask

    task automatic test_beq_train();
        bit pt, act, mis;
        bit [31:0] ptg;
        cycle(32'h100, 1, 32'h100, 32'h140, 3'b000, 0, 1, 0, 32'h0, pt, ptg, act, mis);
        n_cmp++;
        if (act !== 1'b1 || mis !== 1'b1 || pt !== 1'b0) begin
            n_bad++;
            $display("FAIL beq_first: act=%b mis=%b pred=%b, want 1/1/0", act, mis, pt);
        end
        cycle(32'h100, 0, 32'h0, 32'h0, 3'b000, 0, 0, 0, 32'h0, pt, ptg, act, mis);
        n_cmp++;
        if (pt !== 1'b1 || ptg !== 32'h140) begin
            n_bad++;
            $display("FAIL beq_alloc_pred: taken=%b target=%h, want 1/00000140", pt, ptg);
        end
        // Three taken then two not-taken; counter stays >= WT until the final update
        for (int k = 0; k < 5; k++) begin
            bit tk;
            tk = (k < 3);
            cycle(32'h100, 1, 32'h100, 32'h140, 3'b000, 0, tk, 1, 32'h140, pt, ptg, act, mis);
            n_cmp++;
            if (pt !== 1'b1 || mis !== !tk || act !== tk) begin
                n_bad++;
                $display("FAIL beq_train step%0d: pred=%b mis=%b act=%b, want 1/%b/%b", k, pt, mis, act, !tk, tk);
            end
        end
        cycle(32'h100, 0, 32'h0, 32'h0, 3'b000, 0, 0, 0, 32'h0, pt, ptg, act, mis);
        n_cmp++;
        if (pt !== 1'b0 || ptg !== 32'h0) begin
            n_bad++;
            $display("FAIL beq_decayed: taken=%b target=%h, want 0/0", pt, ptg);
        end
    endtask

    task automatic test_funct3_sweep();
        bit pt, act, mis, legal, dir, e_pt, e_mis;
        bit [31:0] ptg, e_ptg, pc, tgt;
        for (int f = 0; f < 8; f++) begin
            for (int c = 0; c < 4; c++) begin
                bit lt, eq;
                lt  = c[1];
                eq  = c[0];
                pc  = 32'h2020 + 32'(f * 4);
                tgt = pc + 32'h40;
                dir = m_dir(3'(f), lt, eq, legal);
                m_predict(pc, e_pt, e_ptg);
                e_mis = legal && ((dir != e_pt) || (dir && e_ptg != tgt));
                cycle(pc, 1, pc, tgt, 3'(f), lt, eq, e_pt, e_ptg, pt, ptg, act, mis);
                n_cmp++;
                if (act !== (legal && dir) || mis !== e_mis || pt !== e_pt || ptg !== e_ptg) begin
                    n_bad++;
                    $display("FAIL sweep f3=%0d lt=%b eq=%b: act=%b mis=%b pred=%b/%h, want %b/%b/%b/%h",
                             f, lt, eq, act, mis, pt, ptg, legal && dir, e_mis, e_pt, e_ptg);
                end
            end
        end
        // Illegal encodings must not have allocated anything
        for (int f = 2; f < 4; f++) begin
            pc = 32'h2020 + 32'(f * 4);
            cycle(pc, 0, 32'h0, 32'h0, 3'b000, 0, 0, 0, 32'h0, pt, ptg, act, mis);
            n_cmp++;
            if (pt !== 1'b0 || ptg !== 32'h0) begin
                n_bad++;
                $display("FAIL illegal_no_write f3=%0d: pred=%b/%h, want 0/0", f, pt, ptg);
            end
        end
    endtask

    task automatic test_alias();
        bit pt, act, mis;
        bit [31:0] ptg;
        cycle(32'h0, 1, 32'h100, 32'h140, 3'b000, 0, 1, 0, 32'h0, pt, ptg, act, mis);
        cycle(32'h0, 1, 32'h1100, 32'h1180, 3'b000, 0, 1, 0, 32'h0, pt, ptg, act, mis);
        cycle(32'h100, 0, 32'h0, 32'h0, 3'b000, 0, 0, 0, 32'h0, pt, ptg, act, mis);
        n_cmp++;
        if (pt !== 1'b0 || ptg !== 32'h0) begin
            n_bad++;
            $display("FAIL alias_old_evicted: pred=%b/%h, want 0/0", pt, ptg);
        end
        cycle(32'h1100, 0, 32'h0, 32'h0, 3'b000, 0, 0, 0, 32'h0, pt, ptg, act, mis);
        n_cmp++;
        if (pt !== 1'b1 || ptg !== 32'h1180) begin
            n_bad++;
            $display("FAIL alias_new_pred: pred=%b/%h, want 1/00001180", pt, ptg);
        end
        // A fresh allocation is weakly taken: one not-taken flips the prediction
        cycle(32'h0, 1, 32'h1100, 32'h1180, 3'b001, 0, 1, 1, 32'h1180, pt, ptg, act, mis);
        cycle(32'h1100, 0, 32'h0, 32'h0, 3'b000, 0, 0, 0, 32'h0, pt, ptg, act, mis);
        n_cmp++;
        if (pt !== 1'b0) begin
            n_bad++;
            $display("FAIL alias_weak_alloc: pred=%b, want 0", pt);
        end
    endtask

    task automatic test_same_cycle_and_reset();
        bit pt, act, mis;
        bit [31:0] ptg;
        cycle(32'h0, 1, 32'h100, 32'h140, 3'b000, 0, 1, 0, 32'h0, pt, ptg, act, mis);
        cycle(32'h100, 1, 32'h100, 32'h180, 3'b000, 0, 1, 1, 32'h140, pt, ptg, act, mis);
        n_cmp++;
        if (pt !== 1'b1 || ptg !== 32'h140 || mis !== 1'b1 || act !== 1'b1) begin
            n_bad++;
            $display("FAIL same_cycle: pred=%b/%h mis=%b act=%b, want 1/00000140/1/1", pt, ptg, mis, act);
        end
        cycle(32'h100, 0, 32'h0, 32'h0, 3'b000, 0, 0, 0, 32'h0, pt, ptg, act, mis);
        n_cmp++;
        if (pt !== 1'b1 || ptg !== 32'h180) begin
            n_bad++;
            $display("FAIL target_retrain: pred=%b/%h, want 1/00000180", pt, ptg);
        end
        // Asynchronous reset between clock edges
        pc_if_i = 32'h100;
        #2;
        rst_ni = 1'b0;
        #1;
        n_cmp++;
        if (pred_taken_o !== 1'b0 || pred_target_o !== 32'h0) begin
            n_bad++;
            $display("FAIL midrun_reset: pred=%b/%h, want 0/0", pred_taken_o, pred_target_o);
        end
        m_reset();
        @(negedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        cycle(32'h1100, 0, 32'h0, 32'h0, 3'b000, 0, 0, 0, 32'h0, pt, ptg, act, mis);
        n_cmp++;
        if (pt !== 1'b0 || ptg !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_cleared_other: pred=%b/%h, want 0/0", pt, ptg);
        end
    endtask

    task automatic test_random();
        bit [31:0] pool [6];
        bit [31:0] tgts [4];
        bit pt, act, mis, legal, dir, e_pt, e_mis, upd, lt, eq, pte;
        bit [31:0] ptg, e_ptg, pc_if, pc_ex, tgt, ptgx;
        bit [2:0] f3;
        pool = '{32'h100, 32'h1100, 32'h204, 32'h2204, 32'h3F0, 32'h0};
        tgts = '{32'h140, 32'h180, 32'h2000, 32'h8000_0000};
        for (int n = 0; n < 400; n++) begin
            pc_if = pool[$urandom_range(5)];
            pc_ex = (n % 7 == 6) ? ($urandom & 32'hFFFF_FFFC) : pool[$urandom_range(5)];
            tgt   = tgts[$urandom_range(3)];
            upd   = ($urandom_range(3) != 0);
            f3    = 3'($urandom_range(7));
            lt    = 1'($urandom_range(1));
            eq    = 1'($urandom_range(1));
            pte   = 1'($urandom_range(1));
            ptgx  = $urandom_range(1) ? tgt : tgts[$urandom_range(3)];
            dir   = m_dir(f3, lt, eq, legal);
            m_predict(pc_if, e_pt, e_ptg);
            e_mis = upd && legal && ((dir != pte) || (dir && ptgx != tgt));
            cycle(pc_if, upd, pc_ex, tgt, f3, lt, eq, pte, ptgx, pt, ptg, act, mis);
            n_cmp++;
            if (pt !== e_pt || ptg !== e_ptg || act !== (upd && legal && dir) || mis !== e_mis) begin
                n_bad++;
                $display("FAIL random #%0d pc_if=%h pc_ex=%h f3=%0d: pred=%b/%h act=%b mis=%b, want %b/%h/%b/%b",
                         n, pc_if, pc_ex, f3, pt, ptg, act, mis, e_pt, e_ptg, upd && legal && dir, e_mis);
            end
        end
    endtask

    initial begin
        drive_idle();
        rst_ni = 1'b0;
        m_reset();
        #2;
        test_reset();
        test_beq_train();
        test_funct3_sweep();
        test_alias();
        test_same_cycle_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
